// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchronise, debounce, edge-detect, sticky pending and combined irq
module edge_detect_multi #(
    parameter int CH      = 8,
    parameter int SYNC_DP = 2,
    parameter int DEB_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CH-1:0]     sig_i,
    input  logic [DEB_W-1:0]  deb_limit_i,
    input  logic [2*CH-1:0]   mode_i,
    input  logic [CH-1:0]     clr_i,
    output logic [CH-1:0]     level_o,
    output logic [CH-1:0]     re_o,
    output logic [CH-1:0]     fe_o,
    output logic [CH-1:0]     pend_o,
    output logic              irq_o
);
    logic [CH-1:0][1:0] mode;
    logic [CH-1:0]      sync_q [SYNC_DP];
    logic [CH-1:0]      sync_d [SYNC_DP];
    logic [CH-1:0]      s;
    logic [CH-1:0]      lvl_q, lvl_d, re_q, re_d, fe_q, fe_d, pend_q, pend_d;
    logic [DEB_W-1:0]   cnt_q [CH];
    logic [DEB_W-1:0]   cnt_d [CH];

    assign mode    = mode_i;
    assign s       = sync_q[SYNC_DP-1];
    assign level_o = lvl_q;
    assign re_o    = re_q;
    assign fe_o    = fe_q;
    assign pend_o  = pend_q;
    assign irq_o   = |pend_q;

    // synchroniser chain: raw input enters stage 0, each stage copies the previous one
    always_comb begin
        sync_d[0] = sig_i;
        for (int k = 1; k < SYNC_DP; k++) sync_d[k] = sync_q[k-1];
    end

    // debounce: accept a new level once the mismatch has outlasted the limit, pulse the edge
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            lvl_d[c] = lvl_q[c];
            re_d[c]  = 1'b0;
            fe_d[c]  = 1'b0;
            cnt_d[c] = '0;
            if (s[c] != lvl_q[c]) begin
                if (cnt_q[c] >= deb_limit_i) begin
                    lvl_d[c] = s[c];
                    re_d[c]  = s[c];
                    fe_d[c]  = ~s[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // pending: a mode-enabled edge sets the flag and wins over a same-cycle clear
    always_comb begin
        for (int c = 0; c < CH; c++)
            pend_d[c] = (re_q[c] & mode[c][0]) | (fe_q[c] & mode[c][1]) | (pend_q[c] & ~clr_i[c]);
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_DP; k++) sync_q[k] <= '0;
            for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
            lvl_q  <= '0;
            re_q   <= '0;
            fe_q   <= '0;
            pend_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_DP; k++) sync_q[k] <= sync_d[k];
            for (int c = 0; c < CH; c++) cnt_q[c] <= cnt_d[c];
            lvl_q  <= lvl_d;
            re_q   <= re_d;
            fe_q   <= fe_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed vectors with hand-computed expectations for edge_detect_multi
module tb_edge_detect_multi;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  sig_i = '0;
    logic [7:0]  deb_limit_i = '0;
    logic [15:0] mode_i = '0;
    logic [7:0]  clr_i = '0;
    logic [7:0]  level_o, re_o, fe_o, pend_o;
    logic        irq_o;
    int          n_chk = 0;
    int          n_ok = 0;

    edge_detect_multi dut (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(sig_i), .deb_limit_i(deb_limit_i),
        .mode_i(mode_i), .clr_i(clr_i), .level_o(level_o), .re_o(re_o),
        .fe_o(fe_o), .pend_o(pend_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_re"}, re_o, 0);
        chk({tag, "_fe"}, fe_o, 0);
        chk({tag, "_pend"}, pend_o, 0);
        chk({tag, "_irq"}, irq_o, 0);
    endtask

    initial begin
        sig_i = 8'hFF;
        tick(3);
        chk_all_zero("rst_hold");
        rst_i = 1'b0;
        tick(2);
        chk("rst_rel_re_early", re_o, 8'h00);
        tick(1);
        chk("rst_rel_re", re_o, 8'hFF);
        chk("rst_rel_level", level_o, 8'hFF);
        tick(1);
        chk("rst_rel_re_width", re_o, 8'h00);
        chk("rst_rel_nopend", pend_o, 8'h00);
        sig_i = 8'h00;
        tick(3);
        chk("all_fe", fe_o, 8'hFF);
        chk("all_fe_level", level_o, 8'h00);
        tick(1);
        chk("all_fe_nopend", irq_o, 0);

        mode_i = 16'h0001;
        sig_i[0] = 1'b1;
        tick(2);
        chk("ch0_level_early", level_o, 8'h00);
        tick(1);
        chk("ch0_level", level_o, 8'h01);
        chk("ch0_re", re_o, 8'h01);
        chk("ch0_pend_early", pend_o, 8'h00);
        tick(1);
        chk("ch0_re_width", re_o, 8'h00);
        chk("ch0_pend", pend_o, 8'h01);
        chk("ch0_irq", irq_o, 1);

        sig_i[0] = 1'b0;
        tick(3);
        chk("ch0_fe", fe_o, 8'h01);
        tick(1);
        sig_i[0] = 1'b1;
        tick(3);
        chk("coll_re", re_o, 8'h01);
        clr_i = 8'h01;
        tick(1);
        clr_i = 8'h00;
        chk("coll_pend_kept", pend_o, 8'h01);
        chk("coll_irq_kept", irq_o, 1);
        clr_i = 8'h01;
        tick(1);
        clr_i = 8'h00;
        chk("clr_pend", pend_o, 8'h00);
        chk("clr_irq", irq_o, 0);

        deb_limit_i = 8'd4;
        sig_i[1] = 1'b1;
        tick(4);
        sig_i[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("glitch_level", level_o, 8'h01);
            chk("glitch_re", re_o, 8'h00);
            tick(1);
        end
        sig_i[1] = 1'b1;
        tick(5);
        sig_i[1] = 1'b0;
        tick(1);
        chk("deb_level_early", level_o, 8'h01);
        tick(1);
        chk("deb_level", level_o, 8'h03);
        chk("deb_re", re_o, 8'h02);
        tick(1);
        chk("deb_re_width", re_o, 8'h00);
        tick(8);
        chk("deb_fall_level", level_o, 8'h01);
        chk("deb_nopend", pend_o, 8'h00);

        deb_limit_i = 8'd0;
        mode_i = 16'h00E1;
        sig_i[4:2] = 3'b111;
        tick(3);
        chk("mode_re", re_o, 8'h1C);
        tick(1);
        chk("mode_pend_rise", pend_o, 8'h08);
        sig_i[4:2] = 3'b000;
        tick(3);
        chk("mode_fe", fe_o, 8'h1C);
        tick(1);
        chk("mode_pend_fall", pend_o, 8'h0C);
        chk("mode_irq", irq_o, 1);

        deb_limit_i = 8'd4;
        sig_i[6] = 1'b1;
        tick(4);
        #2 rst_i = 1'b1;
        #1;
        chk_all_zero("rst_async");
        sig_i = 8'h00;
        tick(2);
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_re", re_o, 8'h00);
            chk("post_rst_pend", pend_o, 8'h00);
            tick(1);
        end
        chk_all_zero("post_rst");

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
